// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter for a shared FIFO write port.
// A grant is held from arbitration until the granted channel's eop word is written.
module fifo_wr_arbiter #(
  parameter int unsigned CH_NUM = 4,
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned CNTW   = 16
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic [CH_NUM-1:0]        ch_valid_i,
  input  logic [CH_NUM*DWIDTH-1:0] ch_data_i,
  input  logic [CH_NUM-1:0]        ch_eop_i,
  output logic [CH_NUM-1:0]        ch_ready_o,
  input  logic                     wr_full_i,
  output logic                     wr_req_o,
  output logic [DWIDTH-1:0]        data_o,
  output logic [CH_NUM-1:0]        grant_o,
  output logic                     busy_o,
  output logic [CNTW-1:0]          pkt_cnt_o
);

  localparam int unsigned IDXW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            r_state;
  logic [CH_NUM-1:0] r_grant;
  logic [IDXW-1:0]   r_last;
  logic [CNTW-1:0]   r_pkt_cnt;

  logic [IDXW-1:0]   w_cand;
  logic [IDXW-1:0]   w_pick;
  logic              w_found;
  logic              w_busy;
  logic              w_g_valid;
  logic              w_g_eop;
  logic [DWIDTH-1:0] w_g_data;
  logic              w_xfer;

  // Round-robin search starting just after the most recently granted channel.
  always_comb begin
    w_cand  = '0;
    w_pick  = '0;
    w_found = 1'b0;
    for (int unsigned i = 1; i <= CH_NUM; i++) begin
      w_cand = IDXW'((32'(r_last) + i) % CH_NUM);
      if (!w_found && ch_valid_i[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // While locked, r_last is the granted channel index.
  assign w_busy    = (r_state == LOCK);
  assign w_g_valid = ch_valid_i[r_last];
  assign w_g_eop   = ch_eop_i[r_last];
  assign w_g_data  = ch_data_i[32'(r_last)*DWIDTH +: DWIDTH];
  assign w_xfer    = w_busy & w_g_valid & ~wr_full_i;

  assign ch_ready_o = r_grant & {CH_NUM{~wr_full_i}};
  assign wr_req_o   = w_xfer;
  assign data_o     = w_busy ? w_g_data : '0;
  assign grant_o    = r_grant;
  assign busy_o     = w_busy;
  assign pkt_cnt_o  = r_pkt_cnt;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_last    <= IDXW'(CH_NUM - 1);
      r_pkt_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found && !wr_full_i) begin
            r_grant <= CH_NUM'(1) << w_pick;
            r_last  <= w_pick;
            r_state <= LOCK;
          end
        end
        LOCK: begin
          if (w_xfer && w_g_eop) begin
            r_grant   <= '0;
            r_pkt_cnt <= r_pkt_cnt + CNTW'(1);
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Packet-aware round-robin arbiter that shares the single write port of the team's FIFO between `CH_NUM` requesting channels. Sits in the write-clock domain directly in front of the FIFO: it selects one channel, holds the grant until that channel's end-of-packet word is written, and drives `wr_req`/`data` into the FIFO under `wr_full` backpressure. Packets from different channels are never interleaved in the FIFO.

## Interface
Parameters:
- `CH_NUM`, 4, number of requesting channels (≥2).
- `DWIDTH`, 8, data word width; must equal the FIFO `DWIDTH`.
- `CNTW`, 16, width of the completed-packet counter.

Ports:
- `clk_i` input 1: single clock (FIFO write clock).
- `srst_i` input 1: synchronous, active-high reset.
- `ch_valid_i` input `CH_NUM`: per-channel word valid.
- `ch_data_i` input `CH_NUM*DWIDTH`: channel k data in bits `[k*DWIDTH +: DWIDTH]`.
- `ch_eop_i` input `CH_NUM`: per-channel last word of packet, qualified by `ch_valid_i`.
- `ch_ready_o` output `CH_NUM`: per-channel word accepted this cycle when `valid & ready`.
- `wr_full_i` input 1: FIFO write-side full flag.
- `wr_req_o` output 1: FIFO write request.
- `data_o` output `DWIDTH`: FIFO write data.
- `grant_o` output `CH_NUM`: one-hot granted channel; all-zero when none is granted.
- `busy_o` output 1: a packet is in progress (state `LOCK`).
- `pkt_cnt_o` output `CNTW`: number of packets completed since reset, wrapping.

## Operation
- Two states: `IDLE` and `LOCK`. A registered `last` pointer holds the index of the most recently granted channel.
- **IDLE:**
  - `grant_o`=0, `ch_ready_o`=0, `wr_req_o`=0.
  - If any `ch_valid_i` is set and `wr_full_i`=0, pick the first valid channel searching `last+1, last+2, …` modulo `CH_NUM`.
  - Register its one-hot grant, set `last` to that index, go to `LOCK`.
  - Otherwise stay in `IDLE`.
- **LOCK (granted channel g):**
  - `ch_ready_o[g] = ~wr_full_i`; all other ready bits are 0.
  - `wr_req_o = ch_valid_i[g] & ~wr_full_i`.
  - `data_o = ch_data_i[g]`.
  - Transfer occurs when `wr_req_o`=1.
  - A transfer with `ch_eop_i[g]`=1 ends the packet: clear the grant, increment `pkt_cnt_o`, go to `IDLE`.
- Valid deasserting mid-packet: stay in `LOCK`, `wr_req_o`=0, no other channel is served.
- `wr_full_i`=1: no transfer. Grant and state are held, and the word is presented again once full drops.
- Single-word packet (`valid & eop` on the first word): one transfer, then `IDLE`.
- `data_o` is 0 whenever `grant_o`=0. Its value while `wr_req_o`=0 in `LOCK` is don't-care.
- Non-granted channels must hold their data/valid; the block never drops a word.
- `pkt_cnt_o` wraps from 2^CNTW−1 to 0.
- **Reset:**
  - `srst_i`=1 at a rising edge forces `IDLE`, `grant_o`=0, `last`=`CH_NUM−1` (so channel 0 wins the first arbitration), and `pkt_cnt_o`=0.
  - Combinationally derived outputs follow from this: `busy_o`=0, `ch_ready_o`=0, `wr_req_o`=0, `data_o`=0.
  - A packet interrupted by reset is abandoned. Its tail is treated as a new packet after reset.

## Timing
- `grant_o`, `busy_o`, `pkt_cnt_o`, state and `last` are registered.
- `ch_ready_o`, `wr_req_o` and `data_o` are combinational from the registered grant, `ch_valid_i` and `wr_full_i`. There is no path from `ch_valid_i` to `grant_o` within a cycle.
- Arbitration latency: a valid asserted in cycle n while `IDLE` (and not full) produces a grant in cycle n+1. The first word is written in n+1 at the earliest.
- Every packet costs one arbitration (`IDLE`) cycle. Back-to-back packets from any channels therefore run at L+1 cycles per L-word packet.
- Inside a packet, throughput is one word per clock while valid and not full.
- `pkt_cnt_o` updates in the cycle after the eop transfer, coincident with `grant_o` returning to 0.

## Test plan
- **Reset:** hold `srst_i` 3 cycles with all channels valid → `grant_o`=0, `wr_req_o`=0, `pkt_cnt_o`=0. The first cycle after reset is the arbitration cycle; the next has `grant_o`=4'b0001.
- **Round robin:** all 4 channels continuously present 2-word packets (data = {ch, word}) → grant order 0,1,2,3,0. Each packet is 3 cycles long. After 8 packets `pkt_cnt_o`=8 and FIFO contents are non-interleaved pairs.
- **Backpressure:** channel 2 sends a 5-word packet while `wr_full_i` is pulsed high for 3 cycles mid-packet → `wr_req_o`=0 and `ch_ready_o[2]`=0 during full. All 5 words are written in order with no duplicates, and the grant is held throughout.
- **Valid gap and lock:** channel 1 drops valid for 4 cycles mid-packet while channel 3 is valid → `grant_o` stays 4'b0010 and channel 3 is not served until channel 1's eop. Channel 3 is then granted next.
- **Single-word packets and wrap:** with `CNTW`=4, channel 0 alone sends 17 single-word packets → each takes 2 cycles, and `pkt_cnt_o` ends at 1.
- **Reset mid-packet:** assert `srst_i` after word 2 of a 4-word packet from channel 3 → grant cleared the next cycle, `last`=3, and after reset channel 0 wins over channel 3 when both are valid.
